// File: rtl/register_write_bank_pkg.sv
// Shared widths, register indices and the flat-bus slice convention for the integer register file.
package register_write_bank_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned FLAT_W   = NUM_REGS * DATA_W;
  localparam int unsigned CNT_W    = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_RA   = ADDR_W'(31);

  // Register k lives at bits [DATA_W*k +: DATA_W] of the flat bus.
  function automatic int unsigned slice_lo(input int unsigned k);
    return k * DATA_W;
  endfunction

endpackage

// File: rtl/decoder_5to32.sv
// One-hot destination decoder; all-zero when not enabled.
module decoder_5to32
  import register_write_bank_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_REGS-1:0] onehot
);

  // Enable gates the index so an unknown addr with en=0 yields zero.
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/register_write_bank.sv
// Write side of the 32x32 integer register file: storage, write decode,
// last-write record for WB-to-ID forwarding, and a committed-write counter.
module register_write_bank
  import register_write_bank_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [FLAT_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0] wr_strobe,
  output logic                last_wr_valid,
  output logic [ADDR_W-1:0]   last_wr_addr,
  output logic [DATA_W-1:0]   last_wr_data,
  output logic [CNT_W-1:0]    wr_count
);

  logic commit;

  decoder_5to32 u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (wr_strobe)
  );

  assign commit = wr_en & (wr_addr != REG_ZERO);

  assign regs_flat[slice_lo(0) +: DATA_W] = '0;

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_reg
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
      if (rst)               q <= '0;
      else if (wr_strobe[k]) q <= wr_data;
    end

    assign regs_flat[slice_lo(k) +: DATA_W] = q;
  end

  // Address/data hold their last committed values when no write commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr_valid <= 1'b0;
      last_wr_addr  <= '0;
      last_wr_data  <= '0;
      wr_count      <= '0;
    end else begin
      last_wr_valid <= commit;
      if (commit) begin
        last_wr_addr <= wr_addr;
        last_wr_data <= wr_data;
        wr_count     <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_register_write_bank.sv
// Scoreboard bench: the driver pushes expected state per cycle, a negedge monitor pops and compares.
module tb_register_write_bank;
  import register_write_bank_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [FLAT_W-1:0]   regs_flat;
  logic [NUM_REGS-1:0] wr_strobe;
  logic                last_wr_valid;
  logic [ADDR_W-1:0]   last_wr_addr;
  logic [DATA_W-1:0]   last_wr_data;
  logic [CNT_W-1:0]    wr_count;

  register_write_bank dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .regs_flat     (regs_flat),
    .wr_strobe     (wr_strobe),
    .last_wr_valid (last_wr_valid),
    .last_wr_addr  (last_wr_addr),
    .last_wr_data  (last_wr_data),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                chk;
    logic [NUM_REGS-1:0] strobe;
    logic [FLAT_W-1:0]   regs;
    logic                lv;
    logic [ADDR_W-1:0]   la;
    logic [DATA_W-1:0]   ld;
    logic [CNT_W-1:0]    cnt;
    int                  hidx;
    logic [DATA_W-1:0]   hval;
    int                  hcnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic              m_lv;
  logic [ADDR_W-1:0] m_la;
  logic [DATA_W-1:0] m_ld;
  logic [CNT_W-1:0]  m_cnt;

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_lv = 1'b0; m_la = '0; m_ld = '0; m_cnt = '0;
  endtask

  function automatic logic [FLAT_W-1:0] model_flat();
    logic [FLAT_W-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = m_regs[k];
    return f;
  endfunction

  task automatic cmp(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle; the record holds state from the previous edge and strobe for these inputs.
  task automatic step(input logic r, input logic en, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic chk,
                      input int hidx = -1, input logic [DATA_W-1:0] hval = '0, input int hcnt = -1);
    exp_t e;
    logic [NUM_REGS-1:0] one = NUM_REGS'(1);
    @(posedge clk); #1;
    rst = r; wr_en = en; wr_addr = a; wr_data = d;
    e.chk = chk;
    e.strobe = en ? (one << a) : '0;
    e.regs = model_flat();
    e.lv = m_lv; e.la = m_la; e.ld = m_ld; e.cnt = m_cnt;
    e.hidx = hidx; e.hval = hval; e.hcnt = hcnt;
    q.push_back(e);
    if (r) model_reset();
    else begin
      m_lv = en && (a != '0);
      if (m_lv) begin
        m_regs[a] = d; m_la = a; m_ld = d; m_cnt = m_cnt + CNT_W'(1);
      end
    end
  endtask

  // Monitor: one record per negedge, compared against the live DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          cmp("wr_strobe", wr_strobe, e.strobe);
          checks++;
          if (regs_flat !== e.regs) begin
            errors++;
            for (int k = 0; k < NUM_REGS; k++)
              if (regs_flat[k*DATA_W +: DATA_W] !== e.regs[k*DATA_W +: DATA_W])
                $display("FAIL regs_flat slice %0d: got %h expected %h", k,
                         regs_flat[k*DATA_W +: DATA_W], e.regs[k*DATA_W +: DATA_W]);
          end
          cmp("last_wr_valid", DATA_W'(last_wr_valid), DATA_W'(e.lv));
          cmp("last_wr_addr", DATA_W'(last_wr_addr), DATA_W'(e.la));
          cmp("last_wr_data", last_wr_data, e.ld);
          cmp("wr_count", DATA_W'(wr_count), DATA_W'(e.cnt));
        end
        if (e.hidx >= 0) cmp($sformatf("hand reg%0d", e.hidx), regs_flat[e.hidx*DATA_W +: DATA_W], e.hval);
        if (e.hcnt >= 0) cmp("hand wr_count", DATA_W'(wr_count), DATA_W'(e.hcnt));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Random prior writes, then two reset cycles (second with a dropped write).
    for (int i = 0; i < 6; i++) step(0, 1, ADDR_W'($urandom), $urandom, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 3, 32'h5, 1);
    step(0, 0, 0, 0, 1, 3, 32'h0, 0);
    // Single write to register 5.
    step(0, 1, 5, 32'hDEADBEEF, 1);
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1);
    // Write to register 0 is discarded.
    step(0, 1, 0, 32'hFFFFFFFF, 1);
    step(0, 0, 0, 0, 1, 0, 32'h0, 1);
    // Unknown address with write disabled.
    step(0, 0, 'x, 'x, 1);
    // Back-to-back writes to ra.
    step(0, 1, REG_RA, 32'h1, 1);
    step(0, 1, REG_RA, 32'h2, 1, 31, 32'h1, 2);
    step(0, 0, 0, 0, 1, 31, 32'h2, 3);
    step(0, 0, 0, 0, 1, 31, 32'h2, 3);
    // Reset beats a simultaneous write.
    step(1, 1, 7, 32'h1234, 1);
    step(0, 0, 0, 0, 1, 7, 32'h0, 0);
    // Fill every register.
    for (int k = 1; k < NUM_REGS; k++) step(0, 1, ADDR_W'(k), DATA_W'(k) * 32'h01010101, 1);
    step(0, 0, 0, 0, 1, 31, 32'h1F1F1F1F, 31);
    step(0, 0, 0, 0, 1, 1, 32'h01010101, 31);
    // Counter wrap.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 1, ADDR_W'((i % 31) + 1), DATA_W'(i), 0);
    step(0, 0, 0, 0, 1, -1, 32'h0, 16'hFFFF);
    step(0, 1, 2, 32'h3, 1);
    step(0, 0, 0, 0, 1, 2, 32'h3, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d records left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
